serial_tx: RTL

Parallel-to-serial transmitter for the lab data path. It accepts a WIDTH-bit word on a single-cycle load strobe and shifts it out on one line as a framed serial stream: start bit, data LSB first, stop bit. Each bit is held for DIV clocks. It is the sending end for words that the data path's load registers capture. The FSM reports busy while a frame is in flight and pulses done at frame end.

---
 rtl/serial_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Each bit is held for DIV clocks; busy covers the whole frame and done marks its last cycle.
module serial_tx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic             so,
   output logic             busy,
   output logic             done
);

   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_n;
   logic [WIDTH-1:0] sr_q, sr_n;
   logic [DW-1:0]    div_q, div_n;
   logic [BW-1:0]    bit_q, bit_n;
   logic             so_n, busy_n, done_n;
   logic             div_last, bit_last;

   assign div_last = (div_q == DW'(DIV - 1));
   assign bit_last = (bit_q == BW'(WIDTH - 1));

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         so      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_n;
         sr_q    <= sr_n;
         div_q   <= div_n;
         bit_q   <= bit_n;
         so      <= so_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   // Next state and next-cycle outputs, so every output leaves a flop
   always_comb begin
      state_n = state_q;
      sr_n    = sr_q;
      div_n   = div_q;
      bit_n   = bit_q;

      unique case (state_q)
         IDLE: begin
            if (ld) begin
               state_n = START;
               sr_n    = d;
               div_n   = '0;
               bit_n   = '0;
            end
         end
         START: begin
            if (div_last) begin
               state_n = DATA;
               div_n   = '0;
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         DATA: begin
            if (div_last) begin
               div_n = '0;
               sr_n  = sr_q >> 1;
               if (bit_last) begin
                  state_n = STOP;
                  bit_n   = '0;
               end else begin
                  bit_n = bit_q + 1'b1;
               end
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         STOP: begin
            if (div_last) begin
               state_n = IDLE;
               div_n   = '0;
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      so_n   = 1'b1;
      busy_n = (state_n != IDLE);
      done_n = (state_n == STOP) && (div_n == DW'(DIV - 1));
      if (state_n == START) begin
         so_n = 1'b0;
      end else if (state_n == DATA) begin
         so_n = sr_n[0];
      end
   end

endmodule
